sys_ctrl: RTL and testbench

Command sequencer between the UART byte link, the register file and the ALU. It parses command frames from UART RX and issues register-file writes and reads. It loads the ALU operands into registers 0 and 1, then fires the ALU. Read data and ALU results are returned as bytes over UART TX.

---
 rtl/sys_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_sys_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// sys_ctrl: command sequencer between the UART byte link, the register file
// and the ALU. Parses RX command frames, issues register-file writes/reads,
// loads ALU operands into registers 0/1, fires the ALU and returns read data
// or ALU results over UART TX.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | waiting for a command byte (AA/BB/CC/DD), others dropped
//  WR_ADDR   | write frame, waiting for the address byte
//  WR_DATA   | write frame, waiting for the data byte
//  RD_ADDR   | read frame, waiting for the address byte
//  RD_WAIT   | read issued, waiting for RdData_VLD
//  OP_A      | ALU frame, waiting for operand A (written to reg 0)
//  OP_B      | ALU frame, waiting for operand B (written to reg 1)
//  ALU_FUN_S | ALU clock enabled, waiting for the function byte
//  ALU_WAIT  | ALU started, waiting for ALU_OUT_VLD
//  TX_SEND   | pending byte ready, waiting for TX_BUSY=0 to strobe it
//  TX_WAIT   | byte strobed, waiting for TX_BUSY=1 before the next step
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR       = 4,
    parameter int FUN_W      = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    TX_BUSY,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [ADDR-1:0]         Address,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    ALU_EN,
    output logic [FUN_W-1:0]        ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] WR_ADDR   = 4'd1;
    localparam logic [3:0] WR_DATA   = 4'd2;
    localparam logic [3:0] RD_ADDR   = 4'd3;
    localparam logic [3:0] RD_WAIT   = 4'd4;
    localparam logic [3:0] OP_A      = 4'd5;
    localparam logic [3:0] OP_B      = 4'd6;
    localparam logic [3:0] ALU_FUN_S = 4'd7;
    localparam logic [3:0] ALU_WAIT  = 4'd8;
    localparam logic [3:0] TX_SEND   = 4'd9;
    localparam logic [3:0] TX_WAIT   = 4'd10;

    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_NOP = DATA_WIDTH'(8'hDD);

    logic [3:0]              state;
    logic [3:0]              state_nxt;
    logic [ADDR-1:0]         addr_buf;
    logic [2*DATA_WIDTH-1:0] tx_buf;
    logic [1:0]              tx_left;

    logic            addr_ld;
    logic            wr_go;
    logic [ADDR-1:0] wr_addr;
    logic            rd_go;
    logic            fun_go;
    logic            rd_cap;
    logic            alu_cap;
    logic            tx_go;
    logic            gate_on;

    // Next-state decode plus one-cycle action requests for the datapath.
    always_comb begin
        state_nxt = state;
        addr_ld   = 1'b0;
        wr_go     = 1'b0;
        wr_addr   = addr_buf;
        rd_go     = 1'b0;
        fun_go    = 1'b0;
        rd_cap    = 1'b0;
        alu_cap   = 1'b0;
        tx_go     = 1'b0;
        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR)
                        state_nxt = WR_ADDR;
                    else if (RX_P_DATA == CMD_RD)
                        state_nxt = RD_ADDR;
                    else if (RX_P_DATA == CMD_OP)
                        state_nxt = OP_A;
                    else if (RX_P_DATA == CMD_NOP)
                        state_nxt = ALU_FUN_S;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_ld   = 1'b1;
                    state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_go     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rd_go     = 1'b1;
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RdData_VLD) begin
                    rd_cap    = 1'b1;
                    state_nxt = TX_SEND;
                end
            end
            OP_A: begin
                if (RX_D_VLD) begin
                    wr_go     = 1'b1;
                    wr_addr   = '0;
                    state_nxt = OP_B;
                end
            end
            OP_B: begin
                if (RX_D_VLD) begin
                    wr_go     = 1'b1;
                    wr_addr   = ADDR'(1);
                    state_nxt = ALU_FUN_S;
                end
            end
            ALU_FUN_S: begin
                if (RX_D_VLD) begin
                    fun_go    = 1'b1;
                    state_nxt = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    alu_cap   = 1'b1;
                    state_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!TX_BUSY) begin
                    tx_go     = 1'b1;
                    state_nxt = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // tx_left was already decremented when the strobe went out
                if (TX_BUSY)
                    state_nxt = (tx_left != 2'd0) ? TX_SEND : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The ALU clock is enabled on the transition into ALU_FUN_S from either
    // the CC path (after operand B) or the DD path.
    assign gate_on = (state_nxt == ALU_FUN_S) && (state != ALU_FUN_S);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Registered outputs, address latch and the TX byte buffer.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            Address     <= '0;
            WrData      <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            addr_buf    <= '0;
            tx_buf      <= '0;
            tx_left     <= 2'd0;
        end else begin
            WrEn     <= wr_go;
            RdEn     <= rd_go;
            ALU_EN   <= fun_go;
            TX_D_VLD <= tx_go;

            if (addr_ld)
                addr_buf <= RX_P_DATA[ADDR-1:0];

            if (wr_go) begin
                Address <= wr_addr;
                WrData  <= RX_P_DATA;
            end else if (rd_go) begin
                Address <= RX_P_DATA[ADDR-1:0];
            end

            if (fun_go)
                ALU_FUN <= RX_P_DATA[FUN_W-1:0];

            if (gate_on)
                CLK_GATE_EN <= 1'b1;
            else if (alu_cap)
                CLK_GATE_EN <= 1'b0;

            // Low byte always goes first; the buffer shifts down after each send.
            if (rd_cap) begin
                tx_buf  <= {{DATA_WIDTH{1'b0}}, RdData};
                tx_left <= 2'd1;
            end else if (alu_cap) begin
                tx_buf  <= ALU_OUT;
                tx_left <= 2'd2;
            end else if (tx_go) begin
                TX_P_DATA <= tx_buf[DATA_WIDTH-1:0];
                tx_buf    <= {{DATA_WIDTH{1'b0}}, tx_buf[2*DATA_WIDTH-1:DATA_WIDTH]};
                tx_left   <= tx_left - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Testbench for sys_ctrl: directed frames followed by random frames, checked
// against a frame-level model of expected strobes and TX bytes.
module tb_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  RdData;
    logic        RdData_VLD;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        TX_BUSY;
    logic        WrEn;
    logic        RdEn;
    logic [3:0]  Address;
    logic [7:0]  WrData;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;

    sys_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .RdData      (RdData),
        .RdData_VLD  (RdData_VLD),
        .ALU_OUT     (ALU_OUT),
        .ALU_OUT_VLD (ALU_OUT_VLD),
        .TX_BUSY     (TX_BUSY),
        .WrEn        (WrEn),
        .RdEn        (RdEn),
        .Address     (Address),
        .WrData      (WrData),
        .ALU_EN      (ALU_EN),
        .ALU_FUN     (ALU_FUN),
        .CLK_GATE_EN (CLK_GATE_EN),
        .TX_P_DATA   (TX_P_DATA),
        .TX_D_VLD    (TX_D_VLD)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Event = {type, payload}: 1 write {0,addr,data}, 2 read {addr},
    // 3 alu {fun}, 4 tx {byte}
    logic [19:0] got_ev[$];
    logic [19:0] exp_ev[$];
    logic [7:0]  env_mem[16];
    logic [7:0]  ref_mem[16];
    int viol_excl  = 0;
    int viol_width = 0;
    int viol_tx    = 0;

    function automatic logic [19:0] ev(input logic [3:0] t, input logic [15:0] p);
        return {t, p};
    endfunction

    function automatic logic [31:0] outs_vec();
        return 32'({WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN,
                    CLK_GATE_EN, TX_P_DATA, TX_D_VLD});
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Environment: register file, UART TX busy model and strobe monitor.
    initial begin : env
        logic p_wr, p_rd, p_alu, p_tx;
        int busy_cnt;
        TX_BUSY = 1'b0;
        busy_cnt = 0;
        p_wr = 1'b0; p_rd = 1'b0; p_alu = 1'b0; p_tx = 1'b0;
        for (int i = 0; i < 16; i++) env_mem[i] = 8'h00;
        forever begin
            @(posedge CLK);
            #1;
            if (WrEn && RdEn) viol_excl++;
            if ((WrEn && p_wr) || (RdEn && p_rd) || (ALU_EN && p_alu) || (TX_D_VLD && p_tx))
                viol_width++;
            p_wr = WrEn; p_rd = RdEn; p_alu = ALU_EN; p_tx = TX_D_VLD;
            if (WrEn) begin
                got_ev.push_back(ev(4'h1, {4'h0, Address, WrData}));
                env_mem[Address] = WrData;
            end
            if (RdEn)   got_ev.push_back(ev(4'h2, {12'h000, Address}));
            if (ALU_EN) got_ev.push_back(ev(4'h3, {12'h000, ALU_FUN}));
            if (TX_D_VLD) begin
                if (TX_BUSY) viol_tx++;
                got_ev.push_back(ev(4'h4, {8'h00, TX_P_DATA}));
            end
            if (TX_BUSY) begin
                if (busy_cnt == 0) TX_BUSY = 1'b0;
                else busy_cnt--;
            end
            if (TX_D_VLD) begin
                TX_BUSY = 1'b1;
                busy_cnt = $urandom_range(1, 4);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_count"}, 32'(got_ev.size()), 32'(exp_ev.size()));
        for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
            chk({tag, "_event"}, 32'(got_ev[i]), 32'(exp_ev[i]));
        got_ev.delete();
        exp_ev.delete();
    endtask

    task automatic wait_done();
        int n = 0;
        while ((got_ev.size() < exp_ev.size() || TX_BUSY) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("tx_timeout", 32'(n < 300), 32'(1));
        repeat (3) @(negedge CLK);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        send_byte(8'hAA);
        send_byte(a);
        send_byte(d);
        chk("wr_strobe", 32'({WrEn, RdEn, TX_D_VLD, Address, WrData}),
            32'({1'b1, 1'b0, 1'b0, a[3:0], d}));
        exp_ev.push_back(ev(4'h1, {4'h0, a[3:0], d}));
        ref_mem[a[3:0]] = d;
        @(negedge CLK);
        chk("wr_single", 32'(WrEn), 32'(0));
        @(negedge CLK);
        check_frame("wr");
    endtask

    task automatic do_read(input logic [7:0] a, input logic drop);
        logic [3:0] a4;
        a4 = a[3:0];
        send_byte(8'hBB);
        send_byte(a);
        chk("rd_strobe", 32'({RdEn, WrEn, Address}), 32'({1'b1, 1'b0, a4}));
        exp_ev.push_back(ev(4'h2, {12'h000, a4}));
        exp_ev.push_back(ev(4'h4, {8'h00, ref_mem[a4]}));
        if (drop) begin
            send_byte(8'h11);
            chk("rd_drop", 32'({WrEn, RdEn, ALU_EN, TX_D_VLD}), 32'(0));
        end else begin
            repeat (2) @(negedge CLK);
        end
        RdData     = env_mem[a4];
        RdData_VLD = 1'b1;
        @(negedge CLK);
        RdData_VLD = 1'b0;
        RdData     = 8'($urandom);
        chk("rd_tx_early", 32'(TX_D_VLD), 32'(0));
        @(negedge CLK);
        chk("rd_tx", 32'({TX_D_VLD, TX_P_DATA}), 32'({1'b1, ref_mem[a4]}));
        wait_done();
        check_frame("rd");
    endtask

    task automatic do_alu(input logic load, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] f, input logic [15:0] val);
        if (load) begin
            send_byte(8'hCC);
            send_byte(a);
            chk("opa_wr", 32'({WrEn, Address, WrData, CLK_GATE_EN}), 32'({1'b1, 4'h0, a, 1'b0}));
            send_byte(b);
            chk("opb_wr", 32'({WrEn, Address, WrData, CLK_GATE_EN}), 32'({1'b1, 4'h1, b, 1'b1}));
            exp_ev.push_back(ev(4'h1, {8'h00, a}));
            exp_ev.push_back(ev(4'h1, {8'h01, b}));
            ref_mem[0] = a;
            ref_mem[1] = b;
        end else begin
            send_byte(8'hDD);
            chk("nop_entry", 32'({WrEn, CLK_GATE_EN}), 32'(2'b01));
        end
        send_byte(f);
        chk("alu_en", 32'({ALU_EN, ALU_FUN, CLK_GATE_EN, WrEn}), 32'({1'b1, f[3:0], 1'b1, 1'b0}));
        exp_ev.push_back(ev(4'h3, {12'h000, f[3:0]}));
        exp_ev.push_back(ev(4'h4, {8'h00, val[7:0]}));
        exp_ev.push_back(ev(4'h4, {8'h00, val[15:8]}));
        repeat ($urandom_range(1, 3)) @(negedge CLK);
        chk("gate_wait", 32'(CLK_GATE_EN), 32'(1));
        ALU_OUT     = val;
        ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
        ALU_OUT     = 16'($urandom);
        chk("gate_off", 32'({CLK_GATE_EN, TX_D_VLD}), 32'(0));
        @(negedge CLK);
        chk("alu_tx0", 32'({TX_D_VLD, TX_P_DATA}), 32'({1'b1, val[7:0]}));
        wait_done();
        check_frame("alu");
    endtask

    task automatic do_junk(input logic [7:0] b);
        send_byte(b);
        chk("junk_strobe", 32'({WrEn, RdEn, ALU_EN, TX_D_VLD}), 32'(0));
        @(negedge CLK);
        RdData_VLD  = 1'b1;
        ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        RdData_VLD  = 1'b0;
        ALU_OUT_VLD = 1'b0;
        @(negedge CLK);
        chk("junk_idle", 32'({TX_D_VLD, CLK_GATE_EN}), 32'(0));
        @(negedge CLK);
        check_frame("junk");
    endtask

    initial begin : stim
        logic [7:0] x, y, z;
        RST         = 1'b0;
        RX_P_DATA   = 8'h00;
        RX_D_VLD    = 1'b0;
        RdData      = 8'h00;
        RdData_VLD  = 1'b0;
        ALU_OUT     = 16'h1234;
        ALU_OUT_VLD = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

        repeat (3) @(negedge CLK);
        chk("reset_outputs", outs_vec(), 32'(0));
        RST = 1'b1;
        @(negedge CLK);

        do_write(8'h05, 8'h3C);
        do_read(8'h05, 1'b0);
        do_alu(1'b1, 8'h07, 8'h09, 8'h00, 16'h0010);
        do_alu(1'b0, 8'h00, 8'h00, 8'h02, 16'hFF01);
        do_junk(8'h55);
        do_read(8'h05, 1'b1);
        do_write(8'h01, 8'h02);

        // Reset in the middle of a write frame
        send_byte(8'hAA);
        send_byte(8'h03);
        RST = 1'b0;
        @(negedge CLK);
        chk("midframe_reset", outs_vec(), 32'(0));
        RST = 1'b1;
        send_byte(8'h02);
        chk("post_reset_no_wr", 32'(WrEn), 32'(0));
        repeat (2) @(negedge CLK);
        check_frame("post_reset");
        do_write(8'h0E, 8'h5A);

        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            x = 8'($urandom);
            y = 8'($urandom);
            z = 8'($urandom);
            case ($urandom_range(0, 4))
                0: do_write(x, y);
                1: do_read(x, 1'($urandom_range(0, 1)));
                2: do_alu(1'b1, x, y, z, 16'($urandom));
                3: do_alu(1'b0, x, y, z, 16'($urandom));
                default: begin
                    if (x == 8'hAA || x == 8'hBB || x == 8'hCC || x == 8'hDD) x = 8'h55;
                    do_junk(x);
                end
            endcase
        end

        for (int i = 0; i < 16; i++)
            chk("regfile_image", 32'(env_mem[i]), 32'(ref_mem[i]));
        chk("wr_rd_overlap", 32'(viol_excl), 32'(0));
        chk("strobe_width", 32'(viol_width), 32'(0));
        chk("tx_while_busy", 32'(viol_tx), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
